mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter for the CPU's single-port data memory (ADDR_WIDTH 6, DATA_WIDTH 16).
- Shares the memory between the CPU load/store path and the monitor/debug port, so memory can be inspected or patched while a program runs.
- Sits between `m_cpu`/monitor logic and `m_memory` inside `top`.
- Serialises accesses through a four-state FSM with round-robin tie-breaking and a one-cycle ack pulse per completed access.

## Interface
- ADDR_WIDTH, 6, memory word-address width
- DATA_WIDTH, 16, memory word width

- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU access request; held high with stable cpu_we/addr/wdata until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_WIDTH  word address
- cpu_wdata  in  DATA_WIDTH  write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_WIDTH  read data; valid while cpu_ack=1, held afterwards
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_ack, dbg_rdata: same as cpu_* for the debug requester
- mem_addr  out  ADDR_WIDTH  memory address (registered)
- mem_we  out  1  memory write enable (registered, one-cycle pulse)
- mem_wdata  out  DATA_WIDTH  memory write data (registered)
- mem_rdata  in  DATA_WIDTH  memory read data; memory samples addr at an edge, data valid the following cycle

## Operation
- FSM states: IDLE -> ISSUE -> READ -> ACK -> IDLE. No other transitions except reset.
- IDLE:
  - If no request is high, stay in IDLE.
  - If exactly one request is high, grant it.
  - If both are high, grant the requester not granted last: `last_grant` flips on every grant; its reset value makes the CPU win the first tie.
  - On grant, register the winner's addr/we/wdata into mem_addr/mem_we/mem_wdata and the winner's id into `grant`, then go to ISSUE.
- ISSUE: mem_* outputs are driven; memory samples them at the end of this cycle. Go to READ.
  - mem_we is cleared at the end of ISSUE, so a write lasts exactly one memory cycle.
- READ:
  - mem_rdata is valid in this cycle.
  - If the access is a read, capture mem_rdata into the granted requester's rdata register at the end of READ.
  - A write does not update rdata.
  - Go to ACK.
- ACK: the granted requester's ack is high for this cycle only. Go to IDLE.
- Requester obligation: sample ack at the edge ending ACK, and at that edge either drop req or present a new command. A req seen high in IDLE is always treated as a new request.
- Request inputs are ignored outside IDLE. A newly raised req waits and is never lost.
- The non-granted requester's ack stays 0 and its rdata is unchanged.
- No address arithmetic. Addresses pass through unchanged (0..2^ADDR_WIDTH-1); there is no wrap logic.

## Timing
- Reset (synchronous, rst=1 at an edge):
  - state=IDLE, last_grant set so the CPU wins the next tie.
  - mem_addr=0, mem_we=0, mem_wdata=0.
  - cpu_ack=dbg_ack=0, cpu_rdata=dbg_rdata=0.
- Latency: req high at edge E0 (state IDLE) -> ack high in the cycle after E2 -> back to IDLE after E3.
- One access per 4 cycles, maximum throughput.
- Reset mid-access (any state):
  - Next cycle is IDLE with mem_we=0.
  - The pending ack is never issued; the requester must re-issue.
  - A write already sampled by memory in ISSUE is not rolled back.
- Both requesters continuously high: grants alternate CPU, DBG, CPU, ... Worst-case wait for either requester is 8 cycles.
- A request is granted in the same IDLE cycle as the previous requester's drop, with no bubble beyond the IDLE cycle.
- Outputs change only at clk edges; no combinational path from inputs to outputs.

## Test plan
- CPU read, memory preloaded mem[1]=8:
  - Stimulus: cpu_req=1, cpu_we=0, cpu_addr=1 at E0.
  - Response: cpu_ack=1 exactly in the cycle after E2, cpu_rdata=8, dbg_ack never asserted.
- DBG write then CPU read-back:
  - Stimulus: dbg writes 16'h0040 to addr 5, then CPU reads addr 5.
  - Response: mem_we pulses exactly once (ISSUE of the DBG access), mem_addr=5, cpu_rdata=64.
  - dbg_rdata stays unchanged after the write.
- Simultaneous requests after reset:
  - Stimulus: cpu_req and dbg_req both held high for 16 cycles, re-presenting after each ack.
  - Response: grant order CPU, DBG, CPU, DBG; acks 4 cycles apart.
- Back-to-back single requester:
  - Stimulus: CPU reads addr 1, 2, 3 consecutively, new command presented at the ack edge.
  - Response: acks at cycles 3, 7, 11 with the preloaded values; no access is serviced twice.
- Reset mid-transaction:
  - Stimulus: assert rst during READ of a CPU read.
  - Response: cpu_ack stays 0, all outputs 0 next cycle, state IDLE.
  - The re-issued request completes normally 4 cycles later.
- Address boundary:
  - Stimulus: DBG writes 16'hFFFF to addr 63, then reads it back.
  - Response: dbg_rdata=16'hFFFF, mem[0] unchanged.

Source files
------------

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Two-requester arbiter that shares a single-port data memory
//                between the CPU load/store path and the monitor/debug port.
//                Accesses are serialised through a four-state FSM
//                (IDLE -> ISSUE -> READ -> ACK). Ties are broken round-robin,
//                and each completed access produces a one-cycle ack pulse.
//
//  Ports       :
//    clk        in   system clock, all state updates on rising edge
//    rst        in   synchronous active-high reset
//    cpu_req    in   CPU request, held with stable command until cpu_ack
//    cpu_we     in   CPU write enable (1 = write, 0 = read)
//    cpu_addr   in   CPU word address
//    cpu_wdata  in   CPU write data
//    cpu_ack    out  CPU one-cycle completion pulse
//    cpu_rdata  out  CPU read data, valid with cpu_ack and held afterwards
//    dbg_*           same set of signals for the debug requester
//    mem_addr   out  memory address (registered)
//    mem_we     out  memory write enable (registered, one-cycle pulse)
//    mem_wdata  out  memory write data (registered)
//    mem_rdata  in   memory read data, valid the cycle after addr is sampled
//
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_ack,
    output logic [DATA_WIDTH-1:0] cpu_rdata,

    input  logic                  dbg_req,
    input  logic                  dbg_we,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    input  logic [DATA_WIDTH-1:0] dbg_wdata,
    output logic                  dbg_ack,
    output logic [DATA_WIDTH-1:0] dbg_rdata,

    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_READ  = 2'd2,
        S_ACK   = 2'd3
    } state_t;

    // Requester identifiers used for grant and last_grant.
    localparam logic c_GRANT_CPU = 1'b0;
    localparam logic c_GRANT_DBG = 1'b1;

    state_t                r_state_q,      w_state_d;
    logic                  r_grant_q,      w_grant_d;
    logic                  r_last_grant_q, w_last_grant_d;
    logic                  r_is_write_q,   w_is_write_d;
    logic [ADDR_WIDTH-1:0] r_mem_addr_q,   w_mem_addr_d;
    logic                  r_mem_we_q,     w_mem_we_d;
    logic [DATA_WIDTH-1:0] r_mem_wdata_q,  w_mem_wdata_d;
    logic                  r_cpu_ack_q,    w_cpu_ack_d;
    logic                  r_dbg_ack_q,    w_dbg_ack_d;
    logic [DATA_WIDTH-1:0] r_cpu_rdata_q,  w_cpu_rdata_d;
    logic [DATA_WIDTH-1:0] r_dbg_rdata_q,  w_dbg_rdata_d;
    logic                  w_pick_dbg;

    // ------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d      = r_state_q;
        w_grant_d      = r_grant_q;
        w_last_grant_d = r_last_grant_q;
        w_is_write_d   = r_is_write_q;
        w_mem_addr_d   = r_mem_addr_q;
        w_mem_we_d     = 1'b0;          // write strobe only ever lasts ISSUE
        w_mem_wdata_d  = r_mem_wdata_q;
        w_cpu_ack_d    = 1'b0;
        w_dbg_ack_d    = 1'b0;
        w_cpu_rdata_d  = r_cpu_rdata_q;
        w_dbg_rdata_d  = r_dbg_rdata_q;

        // Debug wins when it is alone, or on a tie when the CPU was the
        // most recent winner.
        w_pick_dbg = dbg_req && (!cpu_req || (r_last_grant_q == c_GRANT_CPU));

        case (r_state_q)
            S_IDLE: begin
                if (cpu_req || dbg_req) begin
                    w_grant_d      = w_pick_dbg;
                    w_last_grant_d = w_pick_dbg;
                    w_is_write_d   = w_pick_dbg ? dbg_we    : cpu_we;
                    w_mem_we_d     = w_pick_dbg ? dbg_we    : cpu_we;
                    w_mem_addr_d   = w_pick_dbg ? dbg_addr  : cpu_addr;
                    w_mem_wdata_d  = w_pick_dbg ? dbg_wdata : cpu_wdata;
                    w_state_d      = S_ISSUE;
                end
            end

            S_ISSUE: begin
                w_state_d = S_READ;
            end

            S_READ: begin
                // mem_rdata is valid now; capture it together with raising
                // ack so both appear in the ACK cycle.
                if (r_grant_q == c_GRANT_DBG) begin
                    w_dbg_ack_d = 1'b1;
                    if (!r_is_write_q) begin
                        w_dbg_rdata_d = mem_rdata;
                    end
                end else begin
                    w_cpu_ack_d = 1'b1;
                    if (!r_is_write_q) begin
                        w_cpu_rdata_d = mem_rdata;
                    end
                end
                w_state_d = S_ACK;
            end

            S_ACK: begin
                w_state_d = S_IDLE;
            end

            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q      <= S_IDLE;
            r_grant_q      <= c_GRANT_CPU;
            r_last_grant_q <= c_GRANT_DBG;  // CPU wins the first tie
            r_is_write_q   <= 1'b0;
            r_mem_addr_q   <= '0;
            r_mem_we_q     <= 1'b0;
            r_mem_wdata_q  <= '0;
            r_cpu_ack_q    <= 1'b0;
            r_dbg_ack_q    <= 1'b0;
            r_cpu_rdata_q  <= '0;
            r_dbg_rdata_q  <= '0;
        end else begin
            r_state_q      <= w_state_d;
            r_grant_q      <= w_grant_d;
            r_last_grant_q <= w_last_grant_d;
            r_is_write_q   <= w_is_write_d;
            r_mem_addr_q   <= w_mem_addr_d;
            r_mem_we_q     <= w_mem_we_d;
            r_mem_wdata_q  <= w_mem_wdata_d;
            r_cpu_ack_q    <= w_cpu_ack_d;
            r_dbg_ack_q    <= w_dbg_ack_d;
            r_cpu_rdata_q  <= w_cpu_rdata_d;
            r_dbg_rdata_q  <= w_dbg_rdata_d;
        end
    end

    assign mem_addr  = r_mem_addr_q;
    assign mem_we    = r_mem_we_q;
    assign mem_wdata = r_mem_wdata_q;
    assign cpu_ack   = r_cpu_ack_q;
    assign dbg_ack   = r_dbg_ack_q;
    assign cpu_rdata = r_cpu_rdata_q;
    assign dbg_rdata = r_dbg_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Directed self-checking bench for mem_arbiter with a
//                synchronous single-port memory model behind it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int ADDR_WIDTH = 6;
    localparam int DATA_WIDTH = 16;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  cpu_req, cpu_we, dbg_req, dbg_we;
    logic [ADDR_WIDTH-1:0] cpu_addr, dbg_addr;
    logic [DATA_WIDTH-1:0] cpu_wdata, dbg_wdata;
    logic                  cpu_ack, dbg_ack;
    logic [DATA_WIDTH-1:0] cpu_rdata, dbg_rdata;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    logic [DATA_WIDTH-1:0] mem [0:63];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Synchronous memory: address sampled at an edge, data out next cycle.
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_checks++;
        if ({cpu_ack, dbg_ack, mem_we} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_ctrl: acks/we=%b required 000", {cpu_ack, dbg_ack, mem_we});
        end
        n_checks++;
        if ({mem_addr, mem_wdata, cpu_rdata, dbg_rdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: addr=%0d wdata=%h crd=%h drd=%h required all 0",
                     mem_addr, mem_wdata, cpu_rdata, dbg_rdata);
        end
        rst = 1'b0;
    endtask

    task automatic test_cpu_read();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 6'd1;
        for (int k = 0; k < 6; k++) begin
            step();
            n_checks++;
            if (cpu_ack !== (k == 2) || dbg_ack !== 1'b0) begin
                n_fail++;
                $display("FAIL cpu_read_ack k=%0d: cpu_ack=%b dbg_ack=%b required %b 0",
                         k, cpu_ack, dbg_ack, (k == 2));
            end
            if (k == 2) begin
                n_checks++;
                if (cpu_rdata !== 16'd8) begin
                    n_fail++;
                    $display("FAIL cpu_read_data: got %h required 0008", cpu_rdata);
                end
                cpu_req = 1'b0;
            end
        end
    endtask

    task automatic test_dbg_write_cpu_read();
        logic [DATA_WIDTH-1:0] old_drd;
        int we_count;
        old_drd  = dbg_rdata;
        we_count = 0;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 6'd5; dbg_wdata = 16'h0040;
        for (int k = 0; k < 4; k++) begin
            step();
            if (mem_we === 1'b1) we_count++;
            if (k == 0) begin
                n_checks++;
                if (mem_we !== 1'b1 || mem_addr !== 6'd5 || mem_wdata !== 16'h0040) begin
                    n_fail++;
                    $display("FAIL dbg_write_issue: we=%b addr=%0d wdata=%h required 1 5 0040",
                             mem_we, mem_addr, mem_wdata);
                end
            end
            n_checks++;
            if (dbg_ack !== (k == 2) || cpu_ack !== 1'b0) begin
                n_fail++;
                $display("FAIL dbg_write_ack k=%0d: dbg_ack=%b cpu_ack=%b required %b 0",
                         k, dbg_ack, cpu_ack, (k == 2));
            end
            if (k == 2) dbg_req = 1'b0;
        end
        n_checks++;
        if (dbg_rdata !== old_drd) begin
            n_fail++;
            $display("FAIL dbg_write_rdata: got %h required %h", dbg_rdata, old_drd);
        end
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 6'd5;
        for (int k = 0; k < 4; k++) begin
            step();
            if (mem_we === 1'b1) we_count++;
            if (k == 2) begin
                n_checks++;
                if (cpu_ack !== 1'b1 || cpu_rdata !== 16'd64) begin
                    n_fail++;
                    $display("FAIL cpu_readback: ack=%b rdata=%h required 1 0040", cpu_ack, cpu_rdata);
                end
                cpu_req = 1'b0;
            end
        end
        n_checks++;
        if (we_count != 1) begin
            n_fail++;
            $display("FAIL mem_we_pulses: got %0d required 1", we_count);
        end
    endtask

    task automatic test_simultaneous();
        rst = 1'b1;
        step();
        rst = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 6'd1;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 6'd2;
        for (int k = 0; k < 16; k++) begin
            step();
            n_checks++;
            if (cpu_ack !== (k % 8 == 2) || dbg_ack !== (k % 8 == 6)) begin
                n_fail++;
                $display("FAIL tie_acks k=%0d: cpu=%b dbg=%b required %b %b",
                         k, cpu_ack, dbg_ack, (k % 8 == 2), (k % 8 == 6));
            end
            if (k % 4 == 0) begin
                n_checks++;
                if (mem_addr !== ((k % 8 == 0) ? 6'd1 : 6'd2)) begin
                    n_fail++;
                    $display("FAIL tie_order k=%0d: mem_addr=%0d required %0d",
                             k, mem_addr, (k % 8 == 0) ? 1 : 2);
                end
            end
            if (k == 6) begin
                n_checks++;
                if (cpu_rdata !== 16'd8 || dbg_rdata !== 16'd16) begin
                    n_fail++;
                    $display("FAIL tie_rdata: cpu=%h dbg=%h required 0008 0010", cpu_rdata, dbg_rdata);
                end
            end
        end
        cpu_req = 1'b0;
        dbg_req = 1'b0;
    endtask

    task automatic test_back_to_back();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 6'd1;
        for (int k = 0; k < 14; k++) begin
            step();
            n_checks++;
            if (cpu_ack !== (k == 2 || k == 6 || k == 10)) begin
                n_fail++;
                $display("FAIL b2b_ack k=%0d: got %b required %b", k, cpu_ack, (k == 2 || k == 6 || k == 10));
            end
            if (k == 2 || k == 6 || k == 10) begin
                n_checks++;
                if (cpu_rdata !== 16'((k / 4 + 1) * 8)) begin
                    n_fail++;
                    $display("FAIL b2b_data k=%0d: got %h required %h", k, cpu_rdata, 16'((k / 4 + 1) * 8));
                end
                if (k == 10) cpu_req = 1'b0;
                else cpu_addr = 6'(k / 4 + 2);
            end
        end
    endtask

    task automatic test_reset_mid();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 6'd2;
        step();                 // ISSUE
        step();                 // READ
        rst = 1'b1;
        step();                 // reset applied
        rst = 1'b0;
        n_checks++;
        if ({cpu_ack, dbg_ack, mem_we} !== 3'b000 ||
            {mem_addr, mem_wdata, cpu_rdata, dbg_rdata} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset: ack=%b we=%b addr=%0d wdata=%h crd=%h drd=%h required all 0",
                     cpu_ack, mem_we, mem_addr, mem_wdata, cpu_rdata, dbg_rdata);
        end
        for (int k = 0; k < 4; k++) begin
            step();
            n_checks++;
            if (cpu_ack !== (k == 2)) begin
                n_fail++;
                $display("FAIL mid_reissue_ack k=%0d: got %b required %b", k, cpu_ack, (k == 2));
            end
            if (k == 2) begin
                n_checks++;
                if (cpu_rdata !== 16'd16) begin
                    n_fail++;
                    $display("FAIL mid_reissue_data: got %h required 0010", cpu_rdata);
                end
                cpu_req = 1'b0;
            end
        end
    endtask

    task automatic test_addr_boundary();
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 6'd63; dbg_wdata = 16'hFFFF;
        for (int k = 0; k < 4; k++) begin
            step();
            if (k == 0) begin
                n_checks++;
                if (mem_addr !== 6'd63 || mem_we !== 1'b1) begin
                    n_fail++;
                    $display("FAIL bound_issue: addr=%0d we=%b required 63 1", mem_addr, mem_we);
                end
            end
            if (k == 2) dbg_we = 1'b0;  // next command: read back
        end
        for (int k = 0; k < 4; k++) begin
            step();
            if (k == 2) begin
                n_checks++;
                if (dbg_ack !== 1'b1 || dbg_rdata !== 16'hFFFF) begin
                    n_fail++;
                    $display("FAIL bound_read: ack=%b rdata=%h required 1 ffff", dbg_ack, dbg_rdata);
                end
                dbg_req = 1'b0;
            end
        end
        n_checks++;
        if (mem[0] !== 16'h1234) begin
            n_fail++;
            $display("FAIL bound_mem0: got %h required 1234", mem[0]);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 16'(i * 8);
        mem[0] = 16'h1234;
        rst = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
        #2;
        test_reset();
        test_cpu_read();
        test_dbg_write_cpu_read();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid();
        test_addr_boundary();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
